// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t     : controller mode (RUN, MEM_WAIT, ERROR)
//   DEF_REG_ADDR_W : default register index width
//   X0             : index of the hard-wired zero register
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int X0             = 0;

endpackage

// File: rtl/hazard_sat_cnt.sv
// hazard_sat_cnt
// Saturating up-counter with enable and asynchronous active-high reset.
// Ports:
//   clk   in  : clock
//   reset in  : asynchronous active-high reset, clears count
//   en    in  : increment this cycle
//   count out : current value, sticks at all-ones
module hazard_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard controller for the 5-stage RISC-V pipeline. Inserts a one-cycle
// bubble on load-use, squashes IF/ID, ID/EX and EX/MEM on a taken branch
// resolved in MEM, and freezes the whole pipeline while data memory is busy,
// escalating to a sticky error after MAX_WAIT+1 freeze cycles.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// performance counters; otherwise stall_cnt/flush_cnt/wait_cnt read 0.
//
// Handshake with data memory: dmem_req marks a MEM-stage access; the access
// completes in the cycle dmem_ready is high. In RUN, a request without ready
// opens a wait; once waiting, only dmem_ready matters.
//
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   idex_memRead, idex_rd        : EX-stage load flag and destination
//   ifid_rs1/rs2, *_used         : ID-stage sources and whether they are read
//   exmem_branch_taken           : branch in MEM resolved taken
//   dmem_req, dmem_ready         : data memory access / completion
//   ctrl_sel                     : 1 pass control, 0 insert bubble
//   pc_write, ifid_write         : PC and IF/ID write enables
//   ifid_flush/idex_flush/exmem_flush : stage register clears
//   pipe_freeze                  : hold every pipeline register and PC
//   mem_timeout                  : sticky data-memory timeout error
//   stall_cnt/flush_cnt/wait_cnt : performance counters
//   fsm_state                    : debug view of the controller state
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int MAX_WAIT   = 15,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  idex_memRead,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_rs1_used,
    input  logic                  ifid_rs2_used,
    input  logic                  exmem_branch_taken,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  ctrl_sel,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  pipe_freeze,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      wait_cnt,
    output logic [1:0]            fsm_state
);

    localparam int WCNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);

    hz_state_t         state, state_next;
    logic [WCNT_W-1:0] wcnt, wcnt_next;
    logic              timeout_q;

    logic load_use;
    logic resolve;      // pipeline not frozen: branch / load-use may act
    logic stall_evt;
    logic flush_evt;
    logic freeze_evt;

    assign load_use = idex_memRead && (idex_rd != REG_ADDR_W'(X0)) &&
                      ((ifid_rs1_used && (idex_rd == ifid_rs1)) ||
                       (ifid_rs2_used && (idex_rd == ifid_rs2)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wcnt      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
            if (state_next == ERROR) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        wcnt_next   = wcnt;
        resolve     = 1'b0;
        ctrl_sel    = 1'b1;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_freeze = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        freeze_evt  = 1'b0;

        case (state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    freeze_evt  = 1'b1;
                    state_next  = MEM_WAIT;
                    wcnt_next   = WCNT_W'(1);
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    resolve    = 1'b1;
                    state_next = RUN;
                    wcnt_next  = '0;
                end else begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    freeze_evt  = 1'b1;
                    // wcnt counts freeze cycles after the first one, so
                    // hitting MAX_WAIT here means MAX_WAIT+1 frozen cycles.
                    if (wcnt == WCNT_MAX) begin
                        state_next = ERROR;
                    end else begin
                        wcnt_next = wcnt + WCNT_W'(1);
                    end
                end
            end
            ERROR: begin
                pipe_freeze = 1'b1;
                ctrl_sel    = 1'b0;
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
            end
            default: begin
                state_next = RUN;
                wcnt_next  = '0;
            end
        endcase

        // Branch squash outranks load-use: the stalled instruction is on
        // the wrong path anyway, so it is flushed rather than bubbled.
        if (resolve) begin
            if (exmem_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                ctrl_sel    = 1'b0;
                flush_evt   = 1'b1;
            end else if (load_use) begin
                ctrl_sel   = 1'b0;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                stall_evt  = 1'b1;
            end
        end

        // Reset quiesces every control output, not just the registers.
        if (reset) begin
            ctrl_sel    = 1'b0;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            pipe_freeze = 1'b0;
            stall_evt   = 1'b0;
            flush_evt   = 1'b0;
            freeze_evt  = 1'b0;
        end
    end

    assign mem_timeout = timeout_q;
    assign fsm_state   = state;

`ifdef HAZARD_PERF_CNT_EN
    hazard_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_evt),
        .count (stall_cnt)
    );

    hazard_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (flush_evt),
        .count (flush_cnt)
    );

    hazard_sat_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (freeze_evt),
        .count (wait_cnt)
    );
`else
    logic unused_evt;
    assign unused_evt = ^{stall_evt, flush_evt, freeze_evt};
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign wait_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int RW = 5;
  localparam int MW = 4;
  localparam int CW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          idex_memRead;
  logic [RW-1:0] idex_rd, ifid_rs1, ifid_rs2;
  logic          ifid_rs1_used, ifid_rs2_used;
  logic          exmem_branch_taken, dmem_req, dmem_ready;
  logic          ctrl_sel, pc_write, ifid_write;
  logic          ifid_flush, idex_flush, exmem_flush;
  logic          pipe_freeze, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_W(RW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .idex_memRead(idex_memRead), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
    .exmem_branch_taken(exmem_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ctrl_sel(ctrl_sel), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
    .fsm_state(fsm_state)
  );

  logic [7:0] obs;
  assign obs = {ctrl_sel, pc_write, ifid_write, ifid_flush, idex_flush,
                exmem_flush, pipe_freeze, mem_timeout};

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  // in_err: sticky timeout; wlen: freeze cycles spent in the current wait.
  bit m_err  = 1'b0;
  int m_wlen = 0;
  int m_stall = 0, m_flush = 0, m_wait = 0;

  function automatic bit m_lu();
    return idex_memRead && (idex_rd != 0) &&
           ((ifid_rs1_used && idex_rd == ifid_rs1) ||
            (ifid_rs2_used && idex_rd == ifid_rs2));
  endfunction

  function automatic bit m_frz();
    if (m_wlen > 0) return !dmem_ready;
    return dmem_req && !dmem_ready;
  endfunction

  // {ctrl_sel, pc_write, ifid_write, ifid_fl, idex_fl, exmem_fl, freeze, timeout}
  function automatic logic [7:0] model_out();
    if (reset)              return 8'b000_000_0_0;
    if (m_err)              return 8'b000_000_1_1;
    if (m_frz())            return 8'b100_000_1_0;
    if (exmem_branch_taken) return 8'b011_111_0_0;
    if (m_lu())             return 8'b000_000_0_0;
    return 8'b111_000_0_0;
  endfunction

  function automatic hz_state_t m_state();
    if (reset)      return RUN;
    if (m_err)      return ERROR;
    if (m_wlen > 0) return MEM_WAIT;
    return RUN;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < (2 ** CW) - 1) ? v + 1 : v;
  endfunction

  function automatic logic [3*CW-1:0] exp_cnt();
    if (reset) return '0;
`ifdef HAZARD_PERF_CNT_EN
    return {CW'(m_stall), CW'(m_flush), CW'(m_wait)};
`else
    return '0;
`endif
  endfunction

  task automatic model_tick();
    if (reset) begin
      m_err = 0; m_wlen = 0; m_stall = 0; m_flush = 0; m_wait = 0;
    end else if (!m_err) begin
      if (m_frz()) begin
        m_wlen++;
        m_wait = sat_inc(m_wait);
        if (m_wlen > MW) m_err = 1;
      end else begin
        m_wlen = 0;
        if (exmem_branch_taken) m_flush = sat_inc(m_flush);
        else if (m_lu())        m_stall = sat_inc(m_stall);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic mr, input logic [RW-1:0] rd, r1, r2,
                       input logic u1, u2, br, req, rdy);
    idex_memRead = mr; idex_rd = rd; ifid_rs1 = r1; ifid_rs2 = r2;
    ifid_rs1_used = u1; ifid_rs2_used = u2;
    exmem_branch_taken = br; dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 8'h00);
    end
    total++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== '0) begin
      bad++; $display("FAIL reset_counters got=%h want=0", {stall_cnt, flush_cnt, wait_cnt});
    end
    total++;
    if (fsm_state !== RUN) begin
      bad++; $display("FAIL reset_state got=%0d want=%0d", fsm_state, RUN);
    end
    advance();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add x6,x5,x7 in ID; then the bubble has moved into EX
    for (int c = 0; c < 3; c++) begin
      if (c == 0) drive(1, 5, 5, 7, 1, 1, 0, 0, 0);
      else        drive(0, 0, 5, 7, 1, 1, 0, 0, 0);
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL load_use c%0d got=%b want=%b", c, obs, model_out());
      end
      total++;
      if ({stall_cnt, flush_cnt, wait_cnt} !== exp_cnt()) begin
        bad++; $display("FAIL load_use_cnt c%0d got=%h want=%h", c,
                        {stall_cnt, flush_cnt, wait_cnt}, exp_cnt());
      end
      advance();
    end
  endtask

  task automatic test_no_stall();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: drive(1, 0, 0, 0, 1, 1, 0, 0, 0);  // lw x0, ID reads x0
        1: drive(1, 5, 3, 5, 1, 0, 0, 0, 0);  // rs2 matches but unused
        default: drive(1, 9, 9, 2, 0, 1, 0, 0, 1); // ready without req
      endcase
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL no_stall c%0d got=%b want=%b", c, obs, model_out());
      end
      advance();
    end
  endtask

  task automatic test_branch_priority();
    drive(1, 5, 5, 7, 1, 1, 1, 0, 0);
    @(negedge clk);
    total++;
    if (obs !== model_out()) begin
      bad++; $display("FAIL branch_lu got=%b want=%b", obs, model_out());
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== exp_cnt()) begin
      bad++; $display("FAIL branch_cnt got=%h want=%h",
                      {stall_cnt, flush_cnt, wait_cnt}, exp_cnt());
    end
    advance();
  endtask

  task automatic test_mem_wait();
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, (c < 4), (c == 3));
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL mem_wait c%0d got=%b want=%b", c, obs, model_out());
      end
      total++;
      if (fsm_state !== m_state()) begin
        bad++; $display("FAIL mem_wait_state c%0d got=%0d want=%0d", c, fsm_state, m_state());
      end
      total++;
      if ({stall_cnt, flush_cnt, wait_cnt} !== exp_cnt()) begin
        bad++; $display("FAIL mem_wait_cnt c%0d got=%h want=%h", c,
                        {stall_cnt, flush_cnt, wait_cnt}, exp_cnt());
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    drive(1, 5, 5, 0, 1, 0, 1, 1, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (obs !== model_out()) begin
        bad++; $display("FAIL timeout c%0d got=%b want=%b", c, obs, model_out());
      end
      total++;
      if (fsm_state !== m_state()) begin
        bad++; $display("FAIL timeout_state c%0d got=%0d want=%0d", c, fsm_state, m_state());
      end
      advance();
      if (c == 6) dmem_ready = 1'b1;  // late completion must not clear the error
    end
    total++;
    if (mem_timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky got=%b want=1", mem_timeout);
    end
    // asynchronous reset asserted mid-cycle, away from any clock edge
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (obs !== 8'h00) begin
      bad++; $display("FAIL async_reset got=%b want=%b", obs, 8'h00);
    end
    total++;
    if ({stall_cnt, flush_cnt, wait_cnt} !== '0 || fsm_state !== RUN) begin
      bad++; $display("FAIL async_reset_regs got=%h/%0d want=0/%0d",
                      {stall_cnt, flush_cnt, wait_cnt}, fsm_state, RUN);
    end
    advance();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (obs !== 8'b111_000_0_0) begin
      bad++; $display("FAIL post_reset got=%b want=%b", obs, 8'b111_000_0_0);
    end
    advance();
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 1), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
            RW'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 4) == 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0));
      @(negedge clk);
      exp_q.push_back(model_out());
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL random i%0d got=%b want=%b", i, obs, e);
      end
      total++;
      if (fsm_state !== m_state()) begin
        bad++; $display("FAIL random_state i%0d got=%0d want=%0d", i, fsm_state, m_state());
      end
      total++;
      if ({stall_cnt, flush_cnt, wait_cnt} !== exp_cnt()) begin
        bad++; $display("FAIL random_cnt i%0d got=%h want=%h", i,
                        {stall_cnt, flush_cnt, wait_cnt}, exp_cnt());
      end
      advance();
    end
    reset = 1'b0;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("model counters: stall=%0d flush=%0d wait=%0d", m_stall, m_flush, m_wait);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core; drives `muxControl.sel` (bubble insertion), PC and IF/ID write enables, stage flushes, and a whole-pipeline freeze for a multi-cycle data memory. Detects load-use hazards between ID/EX and IF/ID, squashes wrong-path instructions on a taken branch resolved in EX/MEM, and sequences data-memory wait states with a timeout. Sits beside the decode stage; all hazard outputs are same-cycle.

## Interface
- `REG_ADDR_W`, 5, register index width
- `MAX_WAIT`, 15, max dmem wait cycles before timeout (≥1)
- `CNT_W`, 32, perf counter width

- `clk` in 1, core clock
- `reset` in 1, asynchronous, active-high
- `idex_memRead` in 1, instruction in EX is a load
- `idex_rd` in REG_ADDR_W, destination of EX instruction
- `ifid_rs1`, `ifid_rs2` in REG_ADDR_W, sources of ID instruction
- `ifid_rs1_used`, `ifid_rs2_used` in 1, source actually read
- `exmem_branch_taken` in 1, branch in MEM resolved taken
- `dmem_req` in 1, MEM stage accessing data memory this cycle
- `dmem_ready` in 1, data memory completes access this cycle
- `ctrl_sel` out 1, to `muxControl.sel`: 1 pass, 0 bubble
- `pc_write`, `ifid_write` out 1, register write enables
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1, clear stage registers
- `pipe_freeze` out 1, all pipeline registers and PC hold
- `mem_timeout` out 1, sticky error
- `stall_cnt`, `flush_cnt`, `wait_cnt` out CNT_W, perf counters

## Operation
- FSM states (`RUN`, `MEM_WAIT`, `ERROR`); reset → `RUN`, internal wait counter `wcnt` = 0.
- Priority per cycle: ERROR > memory wait > branch flush > load-use > normal.
- Memory wait: in `RUN`, `dmem_req && !dmem_ready` → `pipe_freeze`=1, `pc_write`=`ifid_write`=0, `ctrl_sel`=1, no flushes; next state `MEM_WAIT`, `wcnt`←1. In `MEM_WAIT`: `pipe_freeze`=1 while `!dmem_ready`, `wcnt` increments; `dmem_ready`=1 → freeze drops that cycle, branch/load-use evaluated normally, next state `RUN`, `wcnt`←0. `wcnt`==`MAX_WAIT` with `!dmem_ready` → `ERROR`.
- ERROR: `pipe_freeze`=1, `mem_timeout`=1, `pc_write`=`ifid_write`=0, `ctrl_sel`=0; exited only by reset.
- Branch flush (no freeze): `exmem_branch_taken`=1 → all three flushes=1, `ctrl_sel`=0, `pc_write`=1, `ifid_write`=1; load-use ignored that cycle.
- Load-use: `idex_memRead && idex_rd!=0 && ((ifid_rs1_used && idex_rd==ifid_rs1) || (ifid_rs2_used && idex_rd==ifid_rs2))` → `ctrl_sel`=0, `pc_write`=0, `ifid_write`=0. Exactly one bubble; no state needed.
- Normal: `ctrl_sel`=`pc_write`=`ifid_write`=1, flushes/freeze 0.
- `dmem_req` in `MEM_WAIT` ignored except via `dmem_ready`; `dmem_ready` without `dmem_req` in `RUN` ignored.

## Timing
- All hazard/freeze outputs combinational from state + inputs; zero latency.
- State, `wcnt`, `mem_timeout`, counters update on `posedge clk`.
- While `reset`=1: `ctrl_sel`=0, `pc_write`=0, `ifid_write`=0, flushes 0, `pipe_freeze`=0, `mem_timeout`=0, counters 0.
- Reset mid-`MEM_WAIT`/`ERROR` → `RUN` immediately, `wcnt` cleared.
- Timeout: freeze cycles in a single wait bounded by `MAX_WAIT`+1; `ERROR` entered on the following edge.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cnt` +1 per load-use bubble cycle, `flush_cnt` +1 per branch-flush cycle, `wait_cnt` +1 per freeze cycle (excluding ERROR); all saturate at 2^CNT_W−1, none count while `reset`=1.
- Undefined: counter logic absent, three ports tied to 0.

## Structure
- `hazard_pkg`: `hz_state_t` enum (`RUN`, `MEM_WAIT`, `ERROR`), default `REG_ADDR_W`, `x0` constant.
- Sub-module `hazard_sat_cnt` (enable, saturating, async reset), instantiated three times inside the macro guard.

## Test plan
- EX `lw x5`, ID `add x6,x5,x7` (rs1 used) → one cycle `ctrl_sel`=0, `pc_write`=`ifid_write`=0; next cycle all 1; `stall_cnt`=1.
- EX `lw x0`, ID reads x0; and EX `lw x5`, ID `rs2`=5 with `ifid_rs2_used`=0 → no stall.
- `exmem_branch_taken`=1 with simultaneous load-use match → flushes=1, `pc_write`=1, `ctrl_sel`=0, `stall_cnt` unchanged, `flush_cnt`+1.
- `dmem_req`=1, `dmem_ready` low 3 cycles then high → `pipe_freeze`=1 for 3 cycles, 0 on 4th, `wait_cnt`=3, FSM back to `RUN`.
- `MAX_WAIT`=4, `dmem_ready` never asserted → freeze 5 cycles, then `mem_timeout`=1 sticky, `ctrl_sel`=0; async `reset` pulse mid-cycle clears all to reset values.
